// File: rtl/nios_pb_pkg.sv
// Shared PIO bit map, FSM encoding and mode constants for the packet-buffer <-> NIOS transfer engine.
package nios_pb_pkg;

    // nios_in bit positions (engine -> NIOS)
    localparam int DATA_LSB   = 0;
    localparam int VALID_BIT  = 16;
    localparam int DIR_BIT    = 17;
    localparam int WRACK_BIT  = 18;
    localparam int DONE_BIT   = 30;
    localparam int REQ_BIT    = 31;

    // nios_out bit positions (NIOS -> engine)
    localparam int NVALID_BIT = 16;
    localparam int RDY_BIT    = 30;
    localparam int ACK_BIT    = 31;

    localparam logic MODE_PB2NIOS = 1'b0;
    localparam logic MODE_NIOS2PB = 1'b1;

    localparam logic [31:0] NIOS_IN_RST = 32'h0000_FFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_REQ,
        S_RD_ADDR,
        S_RD_PIPE,
        S_RD_ACK,
        S_WR_WAIT,
        S_WR_REL,
        S_DONE
    } state_t;

endpackage

// File: rtl/nios_pb_xfer_engine_watchdog.sv
// Per-state stall counter: counts enabled cycles since the last state change and flags the LIMIT-th one.
module xfer_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] base;

    // A state change restarts the count in the same cycle, so the first cycle of a state is cycle 1.
    assign base   = clear ? '0 : cnt_reg;
    assign expire = en && (base == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= base + 1'b1;
        end else begin
            cnt_reg <= base;
        end
    end
endmodule

// File: rtl/nios_pb_xfer_engine.sv
// Bidirectional word mover between the packet-buffer RAM and the NIOS PIO handshake pair.
// Optional stall watchdog enabled by defining XFER_TIMEOUT_EN.
module nios_pb_xfer_engine
    import nios_pb_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 9,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_transfer,
    input  logic              mode,
    input  logic [ADDR_W:0]   xfer_len,
    output logic [ADDR_W-1:0] pb_address,
    output logic              pb_wren,
    output logic [DATA_W-1:0] pb_data,
    input  logic [DATA_W-1:0] pb_q,
    output logic [31:0]       nios_in,
    input  logic [31:0]       nios_out,
    output logic              transferred,
    output logic              busy,
    output logic [ADDR_W:0]   words_done,
    output logic              error
);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam int              LW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LW-1:0]   LAT_LAST = LW'(RD_LATENCY - 1);

    state_t            state_reg;
    logic              mode_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   words_reg;
    logic [ADDR_W:0]   words_inc;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] pb_address_reg;
    logic              pb_wren_reg;
    logic [DATA_W-1:0] pb_data_reg;
    logic [31:0]       nios_in_reg;
    logic              transferred_reg;
    logic              busy_reg;
    logic [LW-1:0]     lat_reg;
    logic              unused_bits;

    assign len_clamped = (xfer_len > MAX_LEN) ? MAX_LEN : xfer_len;
    assign words_inc   = words_reg + 1'b1;
    assign unused_bits = &{1'b0, nios_out[29:17], (TIMEOUT_CYCLES > 0)};

`ifdef XFER_TIMEOUT_EN
    state_t state_last_reg;
    logic   error_reg;
    logic   wd_clear;
    logic   wd_en;
    logic   wd_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_last_reg <= S_IDLE;
        end else begin
            state_last_reg <= state_reg;
        end
    end

    assign wd_clear = (state_reg != state_last_reg);
    assign wd_en    = state_reg inside {S_REQ, S_RD_ADDR, S_RD_ACK, S_WR_WAIT, S_WR_REL};

    xfer_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            mode_reg        <= MODE_PB2NIOS;
            len_reg         <= '0;
            words_reg       <= '0;
            pb_address_reg  <= '0;
            pb_wren_reg     <= 1'b0;
            pb_data_reg     <= '0;
            nios_in_reg     <= NIOS_IN_RST;
            transferred_reg <= 1'b1;
            busy_reg        <= 1'b0;
            lat_reg         <= '0;
`ifdef XFER_TIMEOUT_EN
            error_reg       <= 1'b0;
`endif
        end else begin
            pb_wren_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (do_transfer) state_reg <= S_ARM;
                end
                S_ARM: begin
                    // Launch on the falling side of the strobe; mode/len are frozen here.
                    if (!do_transfer) begin
                        mode_reg             <= mode;
                        len_reg              <= len_clamped;
                        words_reg            <= '0;
                        transferred_reg      <= 1'b0;
                        busy_reg             <= 1'b1;
                        nios_in_reg[DIR_BIT] <= mode;
`ifdef XFER_TIMEOUT_EN
                        error_reg            <= 1'b0;
`endif
                        if (len_clamped == '0) begin
                            nios_in_reg[DONE_BIT] <= 1'b1;
                            state_reg             <= S_DONE;
                        end else begin
                            nios_in_reg[REQ_BIT] <= 1'b1;
                            state_reg            <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (nios_out[RDY_BIT]) begin
                        nios_in_reg[REQ_BIT] <= 1'b0;
                        state_reg <= (mode_reg == MODE_NIOS2PB) ? S_WR_WAIT : S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (!nios_out[ACK_BIT]) begin
                        pb_address_reg <= words_reg[ADDR_W-1:0];
                        lat_reg        <= '0;
                        state_reg      <= S_RD_PIPE;
                    end
                end
                S_RD_PIPE: begin
                    if (lat_reg == LAT_LAST) begin
                        nios_in_reg[DATA_LSB +: 16] <= 16'(pb_q);
                        nios_in_reg[VALID_BIT]      <= 1'b1;
                        state_reg                   <= S_RD_ACK;
                    end else begin
                        lat_reg <= lat_reg + 1'b1;
                    end
                end
                S_RD_ACK: begin
                    if (nios_out[ACK_BIT]) begin
                        nios_in_reg[VALID_BIT] <= 1'b0;
                        words_reg              <= words_inc;
                        if (words_inc == len_reg) begin
                            nios_in_reg[DONE_BIT] <= 1'b1;
                            state_reg             <= S_DONE;
                        end else begin
                            state_reg <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (nios_out[NVALID_BIT]) begin
                        pb_data_reg            <= nios_out[DATA_LSB +: DATA_W];
                        pb_address_reg         <= words_reg[ADDR_W-1:0];
                        pb_wren_reg            <= 1'b1;
                        nios_in_reg[WRACK_BIT] <= 1'b1;
                        state_reg              <= S_WR_REL;
                    end
                end
                S_WR_REL: begin
                    if (!nios_out[NVALID_BIT]) begin
                        nios_in_reg[WRACK_BIT] <= 1'b0;
                        words_reg              <= words_inc;
                        if (words_inc == len_reg) begin
                            nios_in_reg[DONE_BIT] <= 1'b1;
                            state_reg             <= S_DONE;
                        end else begin
                            state_reg <= S_WR_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    nios_in_reg[DONE_BIT] <= 1'b0;
                    transferred_reg       <= 1'b1;
                    busy_reg              <= 1'b0;
                    state_reg             <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
`ifdef XFER_TIMEOUT_EN
            // Abort overrides whatever the state logic decided this cycle.
            if (wd_expire) begin
                error_reg         <= 1'b1;
                nios_in_reg[31:16] <= '0;
                pb_wren_reg       <= 1'b0;
                transferred_reg   <= 1'b1;
                busy_reg          <= 1'b0;
                state_reg         <= S_IDLE;
            end
`endif
        end
    end

    assign pb_address  = pb_address_reg;
    assign pb_wren     = pb_wren_reg;
    assign pb_data     = pb_data_reg;
    assign nios_in     = nios_in_reg;
    assign transferred = transferred_reg;
    assign busy        = busy_reg;
    assign words_done  = words_reg;
endmodule

// File: tb/tb_nios_pb_xfer_engine.sv
// Scoreboard bench for nios_pb_xfer_engine: two instances (read latency 1 and 3) share one NIOS model.
module tb_nios_pb_xfer_engine;
    import nios_pb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          do_transfer = 1'b0;
    logic          mode = 1'b0;
    logic          sel = 1'b0;
    logic [AW:0]   xfer_len = '0;
    logic [31:0]   nios_out = '0;

    always #5 clk = ~clk;

    logic          do1, do3;
    logic [AW-1:0] addr1, addr3, a3_d1, a3_d2;
    logic          wren1, wren3, tr1, tr3, busy1, busy3, err1, err3;
    logic [DW-1:0] data1, data3, q1, q3;
    logic [31:0]   nin1, nin3;
    logic [AW:0]   wd1, wd3;

    assign do1 = do_transfer & ~sel;
    assign do3 = do_transfer & sel;

    nios_pb_xfer_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .TIMEOUT_CYCLES(100)) u_dut1 (
        .clk(clk), .rst(rst), .do_transfer(do1), .mode(mode), .xfer_len(xfer_len),
        .pb_address(addr1), .pb_wren(wren1), .pb_data(data1), .pb_q(q1),
        .nios_in(nin1), .nios_out(nios_out), .transferred(tr1), .busy(busy1),
        .words_done(wd1), .error(err1));

    nios_pb_xfer_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(3), .TIMEOUT_CYCLES(100)) u_dut3 (
        .clk(clk), .rst(rst), .do_transfer(do3), .mode(mode), .xfer_len(xfer_len),
        .pb_address(addr3), .pb_wren(wren3), .pb_data(data3), .pb_q(q3),
        .nios_in(nin3), .nios_out(nios_out), .transferred(tr3), .busy(busy3),
        .words_done(wd3), .error(err3));

    // RAM models holding addr ^ A5A5; latency 3 adds two address register stages.
    assign q1 = {7'b0, addr1} ^ 16'hA5A5;
    always @(posedge clk) begin
        a3_d1 <= addr3;
        a3_d2 <= a3_d1;
    end
    assign q3 = {7'b0, a3_d2} ^ 16'hA5A5;

    logic [31:0]   nin;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] data_m;
    logic          wren_m, tr_m, busy_m, err_m;
    logic [AW:0]   wd_m;
    assign nin    = sel ? nin3  : nin1;
    assign addr_m = sel ? addr3 : addr1;
    assign data_m = sel ? data3 : data1;
    assign wren_m = sel ? wren3 : wren1;
    assign tr_m   = sel ? tr3   : tr1;
    assign busy_m = sel ? busy3 : busy1;
    assign err_m  = sel ? err3  : err1;
    assign wd_m   = sel ? wd3   : wd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    logic [15:0] rq[$];
    logic [24:0] wq[$];
    int done_cnt = 0;
    int wren_cnt = 0;
    int req_cnt = 0;
    int t_drop = -1;
    int exp_lat = 2;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data or a RAM write.
    initial begin
        logic pv;
        logic [15:0] re;
        logic [24:0] we;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (nin[VALID_BIT] && !pv) begin
                    check(rq.size() > 0, "rd_expected_pending", 32'(rq.size()), 32'd1);
                    if (rq.size() > 0) begin
                        re = rq.pop_front();
                        check(nin[15:0] == re, "rd_data", 32'(nin[15:0]), 32'(re));
                    end
                    if (t_drop >= 0)
                        check(cyc - t_drop == exp_lat, "rd_latency", 32'(cyc - t_drop), 32'(exp_lat));
                end
                pv = nin[VALID_BIT];
                if (wren_m) begin
                    wren_cnt++;
                    check(wq.size() > 0, "wr_expected_pending", 32'(wq.size()), 32'd1);
                    if (wq.size() > 0) begin
                        we = wq.pop_front();
                        check({addr_m, data_m} == we, "wr_addr_data", 32'({addr_m, data_m}), 32'(we));
                    end
                end
                if (nin[DONE_BIT]) done_cnt++;
                if (nin[REQ_BIT]) req_cnt++;
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic check_reset(input string tag);
        check(nin == 32'h0000_FFFF, {tag, "_nios_in"}, nin, 32'h0000_FFFF);
        check(addr_m == '0, {tag, "_pb_address"}, 32'(addr_m), 32'd0);
        check(wren_m == 1'b0, {tag, "_pb_wren"}, 32'(wren_m), 32'd0);
        check(data_m == '0, {tag, "_pb_data"}, 32'(data_m), 32'd0);
        check(tr_m == 1'b1 && busy_m == 1'b0, {tag, "_tr_busy"}, {30'd0, tr_m, busy_m}, 32'd2);
        check(wd_m == '0, {tag, "_words_done"}, 32'(wd_m), 32'd0);
        check(err_m == 1'b0, {tag, "_error"}, 32'(err_m), 32'd0);
    endtask

    task automatic wait_nin(input int bitn, input logic lvl, input string name, input int limit);
        int n = 0;
        while (nin[bitn] !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(nin[bitn] === lvl, name, 32'(nin[bitn]), 32'(lvl));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(tr_m && !busy_m) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tr_m && !busy_m, name, {30'd0, tr_m, busy_m}, 32'd2);
    endtask

    task automatic launch(input logic m, input logic [AW:0] len);
        mode = m;
        xfer_len = len;
        @(negedge clk);
        do_transfer = 1'b1;
        @(negedge clk);
        do_transfer = 1'b0;
        @(negedge clk);
        mode = ~m;          // post-launch changes must be ignored
        xfer_len = 10'd3;
        check(busy_m && !tr_m, "launch_busy", {30'd0, tr_m, busy_m}, 32'd1);
        check(nin[DIR_BIT] == m, "launch_dir", 32'(nin[DIR_BIT]), 32'(m));
    endtask

    task automatic do_req();
        wait_nin(REQ_BIT, 1'b1, "req_rise", 20);
        nios_out[RDY_BIT] = 1'b1;
        @(negedge clk);
        wait_nin(REQ_BIT, 1'b0, "req_drop", 5);
        nios_out[RDY_BIT] = 1'b0;
    endtask

    task automatic nios_read(input int n, input int ack_dly);
        do_req();
        for (int i = 0; i < n; i++) begin
            wait_nin(VALID_BIT, 1'b1, "rd_valid_rise", 20);
            repeat (ack_dly) @(negedge clk);
            nios_out[ACK_BIT] = 1'b1;
            @(negedge clk);
            wait_nin(VALID_BIT, 1'b0, "rd_valid_drop", 5);
            nios_out[ACK_BIT] = 1'b0;
            t_drop = cyc;
        end
    endtask

    task automatic run_read(input logic s, input int len, input int ack_dly, input int lat);
        int n, d0, w0;
        n = (len > 512) ? 512 : len;
        sel = s;
        for (int i = 0; i < n; i++) rq.push_back(16'(i) ^ 16'hA5A5);
        t_drop = -1;
        exp_lat = lat + 1;
        d0 = done_cnt;
        w0 = wren_cnt;
        launch(MODE_PB2NIOS, (AW+1)'(len));
        nios_read(n, ack_dly);
        wait_idle("rd_idle");
        check(wd_m == (AW+1)'(n), "rd_words_done", 32'(wd_m), 32'(n));
        check(done_cnt - d0 == 1, "rd_done_pulses", 32'(done_cnt - d0), 32'd1);
        check(wren_cnt == w0, "rd_no_wren", 32'(wren_cnt - w0), 32'd0);
        check(rq.size() == 0, "rd_all_words", 32'(rq.size()), 32'd0);
        $display("read  lat=%0d len=%0d words_done=%0d", lat, len, wd_m);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench stopped on cycle budget");
    end

    initial begin
        int d0, r0, w0;
        logic [15:0] wdat [5];
        wdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

        repeat (2) @(negedge clk);
        sel = 1'b0; #1 check_reset("rst1");
        sel = 1'b1; #1 check_reset("rst3");
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_read(1'b0, 256, 3, 1);

        // Zero length: straight to DONE, no request.
        r0 = req_cnt;
        d0 = done_cnt;
        launch(MODE_PB2NIOS, '0);
        check(nin[DONE_BIT] == 1'b1, "len0_done_now", 32'(nin[DONE_BIT]), 32'd1);
        @(negedge clk);
        check(tr_m && !busy_m, "len0_idle", {30'd0, tr_m, busy_m}, 32'd2);
        check(req_cnt == r0, "len0_no_req", 32'(req_cnt - r0), 32'd0);
        check(done_cnt - d0 == 1, "len0_done_pulses", 32'(done_cnt - d0), 32'd1);
        $display("read  len=0 words_done=%0d", wd_m);

        run_read(1'b1, 4, 1, 3);
        run_read(1'b1, 1023, 0, 3);

        // Reset in the middle of a read, then restart from address 0.
        sel = 1'b0;
        for (int i = 0; i < 20; i++) rq.push_back(16'(i) ^ 16'hA5A5);
        t_drop = -1;
        exp_lat = 2;
        launch(MODE_PB2NIOS, 10'd20);
        nios_read(7, 1);
        check(wd_m == 10'd7, "mid_words_done", 32'(wd_m), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rq.delete();
        check_reset("midrst");
        rst = 1'b0;
        nios_out = '0;
        @(negedge clk);
        $display("reset at words_done=7");
        run_read(1'b0, 3, 1, 1);

        // Write path.
        sel = 1'b0;
        for (int i = 0; i < 5; i++) wq.push_back({9'(i), wdat[i]});
        d0 = done_cnt;
        w0 = wren_cnt;
        launch(MODE_NIOS2PB, 10'd5);
        do_req();
        for (int i = 0; i < 5; i++) begin
            nios_out[15:0] = wdat[i];
            nios_out[NVALID_BIT] = 1'b1;
            @(negedge clk);
            check(nin[WRACK_BIT] == 1'b1, "wr_ack_rise", 32'(nin[WRACK_BIT]), 32'd1);
            nios_out[NVALID_BIT] = 1'b0;
            @(negedge clk);
            check(nin[WRACK_BIT] == 1'b0, "wr_ack_fall", 32'(nin[WRACK_BIT]), 32'd0);
        end
        wait_idle("wr_idle");
        check(wd_m == 10'd5, "wr_words_done", 32'(wd_m), 32'd5);
        check(wren_cnt - w0 == 5, "wr_pulses", 32'(wren_cnt - w0), 32'd5);
        check(done_cnt - d0 == 1, "wr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check(wq.size() == 0, "wr_all_words", 32'(wq.size()), 32'd0);
        $display("write len=5 words_done=%0d", wd_m);

`ifdef XFER_TIMEOUT_EN
        // NIOS never raises rdy: abort on REQ cycle 100.
        sel = 1'b0;
        launch(MODE_PB2NIOS, 10'd4);
        repeat (99) @(negedge clk);
        check(err_m == 1'b0 && nin[REQ_BIT], "tmo_before", {30'd0, err_m, nin[REQ_BIT]}, 32'd1);
        @(negedge clk);
        check(err_m == 1'b1, "tmo_error", 32'(err_m), 32'd1);
        check(nin[31:16] == 16'd0, "tmo_pio_clear", 32'(nin[31:16]), 32'd0);
        check(tr_m && !busy_m, "tmo_idle", {30'd0, tr_m, busy_m}, 32'd2);
        launch(MODE_PB2NIOS, '0);
        check(err_m == 1'b0, "tmo_relaunch_clear", 32'(err_m), 32'd0);
        wait_idle("tmo_relaunch_idle");
        $display("timeout abort and relaunch");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
